adc_trig_capture: RTL and testbench
===================================

Name: adc_trig_capture

Overview:
- Downstream consumer of the 2's-complement ADC channel data produced by the ADC/DAC interface, running in the ADC clock domain.
- Implements a triggered acquisition controller: arm, pre-trigger fill, trigger wait with level/hysteresis detection, and post-trigger count.
- Streams samples into an external simple-dual-port BRAM write port through a circular buffer.
- The host reads the record from the BRAM's other port after done_o.

Parameters:
DW, 14, sample width (signed 2's complement)
AW, 13, BRAM address width; buffer depth 2^AW samples

Ports:
adc_clk_i  in  1  ADC clock; sole clock
adc_rst_i  in  1  synchronous reset, active-high
adc_dat_i  in  DW  signed ADC sample, one per clock
arm_i  in  1  start capture (level, sampled each clock)
abort_i  in  1  return to IDLE
trig_src_i  in  2  0=software only, 1=level rising, 2=level falling, 3=external rising edge
trig_sw_i  in  1  force trigger (any trig_src_i)
trig_ext_i  in  1  asynchronous external trigger
trig_level_i  in  DW  signed threshold
trig_hyst_i  in  DW  unsigned hysteresis
pretrig_i  in  AW  samples to write before trigger is accepted
posttrig_i  in  AW  samples written from trigger sample inclusive; 0 treated as 1
bram_addr_o  out  AW  write address
bram_dat_o  out  DW  write data
bram_we_o  out  1  write enable
trig_addr_o  out  AW  address holding the trigger sample
busy_o  out  1  high in PRE/WAIT/POST
triggered_o  out  1  high in POST/DONE
done_o  out  1  high in DONE

Behaviour:
- Reset: state=IDLE; all outputs 0; write pointer 0; hysteresis flags 0; external-trigger synchroniser cleared.
- Data path:
  - adc_dat_i is registered once.
  - bram_dat_o = sample registered at cycle n, presented at n+1.
  - bram_we_o = 1 in PRE, WAIT and POST.
  - Pointer increments after every write, modulo 2^AW (wraps AW'h1FFF->0).
  - First write after arm is at address 0.
- FSM:
  - IDLE: arm_i=1 -> PRE; pointer and pre_cnt cleared.
  - PRE: pre_cnt increments per write. When pre_cnt==pretrig_i -> WAIT. pretrig_i=0 -> WAIT after exactly one PRE cycle (that sample is still written). Triggers ignored.
  - WAIT: circular writes continue. On trigger qualified in a cycle: trig_addr_o <= address written that cycle, post_cnt=1, -> POST. If max(posttrig_i,1)==1 -> DONE directly.
  - POST: post_cnt increments per write. The cycle writing sample number max(posttrig_i,1) is the last write; next state DONE.
  - DONE: no writes; done_o=1. arm_i=1 -> PRE (re-arm; pointer reset; trig_addr_o held until the new trigger).
- arm_i is ignored in PRE/WAIT/POST.
- abort_i=1 in any state -> IDLE next cycle; bram_we_o=0 from that cycle. abort_i has priority over arm_i and over a trigger in the same cycle.
- Trigger qualification: evaluated on the registered sample s, only in WAIT. Comparisons use DW+2-bit signed arithmetic; no overflow allowed.
  - Rising: flag r_arm set when s < level-hyst. Fires when r_arm && s >= level; firing clears r_arm.
  - Falling: f_arm set when s > level+hyst. Fires when f_arm && s <= level.
  - Flags update in PRE and WAIT, so PRE samples may pre-arm. Flags are cleared in IDLE/DONE.
  - External: trig_ext_i passes through a 2-FF synchroniser, then rising-edge detect. Latency is 3 cycles from pin to qualification.
  - trig_sw_i fires in WAIT regardless of trig_src_i.
- Record start address = trig_addr_o - pretrig_i (mod 2^AW). No clamping when pretrig_i+posttrig_i > 2^AW; the oldest data is overwritten.
- trig_level_i, trig_hyst_i and trig_src_i may change at any time and take effect on the next comparison. pretrig_i and posttrig_i must be stable while busy_o=1.

Optional Feature:
- Macro TRIG_TIMESTAMP_EN.
- When defined:
  - Adds output trig_ts_o [63:0].
  - A 64-bit free-running counter is cleared by reset only and increments every clock.
  - On the trigger cycle its value is latched into trig_ts_o, which holds until the next trigger.
  - trig_ts_o resets to 0.
- Not defined: no counter, no port.

Test Plan:
- AW=4, pretrig_i=3, posttrig_i=5, trig_src_i=1, level=100, hyst=10; ramp -20..200 step 1. Expected:
  - samples <90 arm r_arm; first s>=100 fires.
  - trig_addr_o = its address.
  - exactly 5 writes from the trigger sample, then done_o=1.
  - bram_we_o low in DONE.
- Falling, level=0, hyst=50; input oscillates +30/-30. Expected: never fires (f_arm never set). Then one +60 sample followed by -1. Expected: fires on -1.
- pretrig_i=0, posttrig_i=0, trig_sw_i held high before arm. Expected: one PRE write at addr 0, trigger at addr 1, DONE after one post write.
- AW=4, pretrig_i=2, trigger delayed 20 cycles. Expected: bram_addr_o wraps 15->0, and trig_addr_o = 20 mod 16 = 4 (the 21st write).
- trig_ext_i rising edge at cycle t in WAIT. Expected: trigger qualified at t+3. Then abort_i together with arm_i mid-POST. Expected: IDLE next cycle, we=0, done_o=0.
- With TRIG_TIMESTAMP_EN, software trigger at 1000 cycles after reset release. Expected: trig_ts_o=1000 ±pipeline constant, checked exactly against the model.

Source files
------------

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: triggered ADC acquisition (arm, pre-fill, level/hysteresis/ext/sw trigger, post count) into a circular BRAM.
// Define TRIG_TIMESTAMP_EN to add a 64-bit free-running counter latched into trig_ts_o on the trigger cycle.
module adc_trig_capture #(
    parameter int DW = 14,
    parameter int AW = 13
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic [DW-1:0] adc_dat_i,
    input  logic          arm_i,
    input  logic          abort_i,
    input  logic [1:0]    trig_src_i,
    input  logic          trig_sw_i,
    input  logic          trig_ext_i,
    input  logic [DW-1:0] trig_level_i,
    input  logic [DW-1:0] trig_hyst_i,
    input  logic [AW-1:0] pretrig_i,
    input  logic [AW-1:0] posttrig_i,
    output logic [AW-1:0] bram_addr_o,
    output logic [DW-1:0] bram_dat_o,
    output logic          bram_we_o,
    output logic [AW-1:0] trig_addr_o,
    output logic          busy_o,
    output logic          triggered_o,
    output logic          done_o
`ifdef TRIG_TIMESTAMP_EN
    ,
    output logic [63:0]   trig_ts_o
`endif
);
    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] s_q;
    logic [AW-1:0] ptr, pre_cnt, post_cnt, post_eff;
    logic [1:0] ext_sync;
    logic ext_d, ext_pulse, r_arm, f_arm, rise_hit, fall_hit, trig, start, flag_en;
    logic signed [DW+1:0] s_x, lvl_x, hyst_x, lo, hi;
    // Two guard bits keep level +/- hysteresis exact for any input combination.
    assign s_x = {{2{s_q[DW-1]}}, s_q};
    assign lvl_x = {{2{trig_level_i[DW-1]}}, trig_level_i};
    assign hyst_x = {2'b00, trig_hyst_i};
    assign lo = lvl_x - hyst_x;
    assign hi = lvl_x + hyst_x;
    assign rise_hit = r_arm && s_x >= lvl_x;
    assign fall_hit = f_arm && s_x <= lvl_x;
    assign post_eff = posttrig_i == '0 ? AW'(1) : posttrig_i;
    assign flag_en = state == PRE || state == WAIT;
    assign trig = state == WAIT && !abort_i && (trig_sw_i || (trig_src_i == 2'd1 && rise_hit) ||
                  (trig_src_i == 2'd2 && fall_hit) || (trig_src_i == 2'd3 && ext_pulse));
    assign start = (state == IDLE || state == DONE) && arm_i && !abort_i;
    assign busy_o = state == PRE || state == WAIT || state == POST;
    assign bram_we_o = busy_o;
    assign bram_addr_o = ptr;
    assign bram_dat_o = s_q;
    assign triggered_o = state == POST || state == DONE;
    assign done_o = state == DONE;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = arm_i ? PRE : state;
            PRE:        state_nxt = pre_cnt == pretrig_i ? WAIT : PRE;
            WAIT:       state_nxt = trig ? (post_eff == AW'(1) ? DONE : POST) : WAIT;
            POST:       state_nxt = post_cnt + AW'(1) == post_eff ? DONE : POST;
            default:    state_nxt = IDLE;
        endcase
        if (abort_i) state_nxt = IDLE;
    end
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state <= IDLE;
            s_q <= '0;
            ptr <= '0;
            pre_cnt <= '0;
            post_cnt <= '0;
            trig_addr_o <= '0;
            r_arm <= 1'b0;
            f_arm <= 1'b0;
            ext_sync <= '0;
            ext_d <= 1'b0;
            ext_pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            s_q <= adc_dat_i;
            ext_sync <= {ext_sync[0], trig_ext_i};
            ext_d <= ext_sync[1];
            ext_pulse <= ext_sync[1] & ~ext_d;
            ptr <= start ? '0 : busy_o ? ptr + AW'(1) : ptr;
            pre_cnt <= start ? '0 : state == PRE ? pre_cnt + AW'(1) : pre_cnt;
            post_cnt <= trig ? AW'(1) : state == POST ? post_cnt + AW'(1) : post_cnt;
            trig_addr_o <= trig ? ptr : trig_addr_o;
            r_arm <= flag_en && (s_x < lo || (r_arm && !(state == WAIT && rise_hit)));
            f_arm <= flag_en && (s_x > hi || (f_arm && !(state == WAIT && fall_hit)));
        end
    end
`ifdef TRIG_TIMESTAMP_EN
    logic [63:0] ts;
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            ts <= '0;
            trig_ts_o <= '0;
        end else begin
            ts <= ts + 64'd1;
            trig_ts_o <= trig ? ts : trig_ts_o;
        end
    end
`endif
endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: randomized and directed checks of adc_trig_capture against a sample-index reference model.
module tb_adc_trig_capture;
    localparam int DW = 14;
    localparam int AW = 4;
    localparam int NONE = 100000;
    logic adc_clk_i = 1'b0, adc_rst_i = 1'b1, arm_i = 1'b0, abort_i = 1'b0;
    logic trig_sw_i = 1'b0, trig_ext_i = 1'b0;
    logic [1:0] trig_src_i = '0;
    logic [DW-1:0] adc_dat_i = '0, trig_level_i = '0, trig_hyst_i = '0;
    logic [AW-1:0] pretrig_i = '0, posttrig_i = '0;
    logic [AW-1:0] bram_addr_o, trig_addr_o;
    logic [DW-1:0] bram_dat_o;
    logic bram_we_o, busy_o, triggered_o, done_o;
`ifdef TRIG_TIMESTAMP_EN
    logic [63:0] trig_ts_o;
`endif
    int checks = 0, failures = 0;
    logic [DW-1:0] smp[$];
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    longint wc[$];
    longint cyc = 0;
    logic [AW-1:0] ta_first;

    adc_trig_capture #(.DW(DW), .AW(AW)) dut (
        .adc_clk_i(adc_clk_i), .adc_rst_i(adc_rst_i), .adc_dat_i(adc_dat_i),
        .arm_i(arm_i), .abort_i(abort_i), .trig_src_i(trig_src_i), .trig_sw_i(trig_sw_i),
        .trig_ext_i(trig_ext_i), .trig_level_i(trig_level_i), .trig_hyst_i(trig_hyst_i),
        .pretrig_i(pretrig_i), .posttrig_i(posttrig_i), .bram_addr_o(bram_addr_o),
        .bram_dat_o(bram_dat_o), .bram_we_o(bram_we_o), .trig_addr_o(trig_addr_o),
        .busy_o(busy_o), .triggered_o(triggered_o), .done_o(done_o)
`ifdef TRIG_TIMESTAMP_EN
        , .trig_ts_o(trig_ts_o)
`endif
    );

    always #5 adc_clk_i = ~adc_clk_i;
    always @(posedge adc_clk_i) cyc <= adc_rst_i ? 0 : cyc + 1;
    always @(negedge adc_clk_i) begin
        if (bram_we_o === 1'b1) begin
            if (wa.size() == 0) ta_first = trig_addr_o;
            wa.push_back(bram_addr_o);
            wd.push_back(bram_dat_o);
            wc.push_back(cyc);
        end
    end

    // Write k carries smp[k]; PRE covers writes 0..pre, so triggers are accepted from write pre+1.
    function automatic int model_k(input int src, input int lvl, input int hyst, input int pre,
                                   input int sw_from, input int ext_from);
        bit ra, fa;
        int x;
        ra = 0;
        fa = 0;
        for (int k = 0; k < smp.size(); k++) begin
            x = int'($signed(smp[k]));
            if (k > pre && (k >= sw_from || (src == 1 && ra && x >= lvl) ||
                (src == 2 && fa && x <= lvl) || (src == 3 && k == ext_from + 2))) return k;
            if (x < lvl - hyst) ra = 1;
            if (x > lvl + hyst) fa = 1;
        end
        return -1;
    endfunction

    task automatic capture(input int src, input int lvl, input int hyst, input int pre, input int post,
                           input int sw_from, input int ext_from, input int abort_at,
                           output bit done_seen, output logic [3:0] st);
        trig_src_i = 2'(src);
        trig_level_i = DW'(lvl);
        trig_hyst_i = DW'(hyst);
        pretrig_i = AW'(pre);
        posttrig_i = AW'(post);
        wa.delete();
        wd.delete();
        wc.delete();
        done_seen = 0;
        st = 'x;
        for (int i = 0; i < 400; i++) begin
            adc_dat_i = i < smp.size() ? smp[i] : smp[smp.size() - 1];
            arm_i = i == 0 || i == abort_at;
            abort_i = i == abort_at;
            trig_sw_i = i - 1 >= sw_from;
            trig_ext_i = i >= ext_from;
            @(negedge adc_clk_i);
            if (done_o === 1'b1 || i >= abort_at) begin
                done_seen = done_o === 1'b1;
                st = {busy_o, bram_we_o, done_o, triggered_o};
                break;
            end
        end
        arm_i = 0;
        abort_i = 0;
        trig_sw_i = 0;
        trig_ext_i = 0;
        @(negedge adc_clk_i);
    endtask

    task automatic test_reset;
        adc_rst_i = 1;
        adc_dat_i = 14'h1abc;
        arm_i = 1;
        repeat (3) @(negedge adc_clk_i);
        checks++;
        if ({bram_addr_o, bram_dat_o, bram_we_o, trig_addr_o, busy_o, triggered_o, done_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bram_addr_o, bram_dat_o, bram_we_o, trig_addr_o, busy_o, triggered_o, done_o});
        end
        arm_i = 0;
        adc_rst_i = 0;
        repeat (2) @(negedge adc_clk_i);
        checks++;
        if ({busy_o, bram_we_o, done_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=000", {busy_o, bram_we_o, done_o});
        end
    endtask

    task automatic test_rise;
        bit dn;
        logic [3:0] st;
        int k;
        smp.delete();
        for (int v = -20; v <= 200; v++) smp.push_back(DW'(v));
        k = model_k(1, 100, 10, 3, NONE, NONE);
        capture(1, 100, 10, 3, 5, NONE, NONE, NONE, dn, st);
        checks++;
        if (dn !== 1'b1) begin failures++; $display("FAIL rise_done got=%b exp=1", dn); end
        checks++;
        if (trig_addr_o !== AW'(k)) begin failures++; $display("FAIL rise_trig_addr got=%0d exp=%0d", trig_addr_o, AW'(k)); end
        checks++;
        if (wa.size() !== k + 5) begin failures++; $display("FAIL rise_writes got=%0d exp=%0d", wa.size(), k + 5); end
        checks++;
        if (!(wa.size() > k && wd[k] === smp[k])) begin failures++; $display("FAIL rise_trig_sample exp=%0d", smp[k]); end
        checks++;
        if ({bram_we_o, busy_o, triggered_o} !== 3'b001) begin
            failures++;
            $display("FAIL rise_done_flags got=%b exp=001", {bram_we_o, busy_o, triggered_o});
        end
    endtask

    task automatic test_fall;
        bit dn;
        logic [3:0] st;
        int k;
        smp.delete();
        for (int i = 0; i < 40; i++) smp.push_back(i % 2 ? DW'(-30) : DW'(30));
        smp.push_back(DW'(60));
        smp.push_back(DW'(-1));
        repeat (10) smp.push_back('0);
        k = model_k(2, 0, 50, 3, NONE, NONE);
        capture(2, 0, 50, 3, 4, NONE, NONE, NONE, dn, st);
        checks++;
        if (trig_addr_o !== AW'(k)) begin failures++; $display("FAIL fall_trig_addr got=%0d exp=%0d", trig_addr_o, AW'(k)); end
        checks++;
        if (!(wa.size() > k && wd[k] === 14'h3fff)) begin failures++; $display("FAIL fall_trig_sample exp=-1 at write %0d", k); end
        checks++;
        if (wa.size() !== k + 4 || dn !== 1'b1) begin
            failures++;
            $display("FAIL fall_writes got=%0d/%b exp=%0d/1", wa.size(), dn, k + 4);
        end
    endtask

    task automatic test_min;
        bit dn;
        logic [3:0] st;
        smp.delete();
        repeat (8) smp.push_back(DW'($urandom));
        capture(0, 0, 0, 0, 0, -1, NONE, NONE, dn, st);
        checks++;
        if (wa.size() !== 2 || dn !== 1'b1) begin failures++; $display("FAIL min_writes got=%0d/%b exp=2/1", wa.size(), dn); end
        checks++;
        if (wa.size() < 2 || {wa[0], wa[1]} !== {4'd0, 4'd1}) begin failures++; $display("FAIL min_addrs exp=0,1"); end
        checks++;
        if (trig_addr_o !== 4'd1) begin failures++; $display("FAIL min_trig_addr got=%0d exp=1", trig_addr_o); end
    endtask

    task automatic test_back_to_back;
        bit dn;
        logic [3:0] st;
        logic [AW-1:0] prev;
        int k;
        prev = trig_addr_o;
        smp.delete();
        repeat (40) smp.push_back(DW'($urandom));
        k = model_k(0, 0, 0, 2, 20, NONE);
        capture(0, 0, 0, 2, 3, 20, NONE, NONE, dn, st);
        checks++;
        if (ta_first !== prev) begin failures++; $display("FAIL rearm_trig_hold got=%0d exp=%0d", ta_first, prev); end
        checks++;
        if (trig_addr_o !== 4'd4 || k !== 20) begin failures++; $display("FAIL wrap_trig_addr got=%0d exp=4", trig_addr_o); end
        checks++;
        if (wa.size() !== 23) begin failures++; $display("FAIL wrap_writes got=%0d exp=23", wa.size()); end
        for (int i = 0; i < wa.size() && i < 23; i++) begin
            checks++;
            if (wa[i] !== AW'(i) || wd[i] !== smp[i]) begin
                failures++;
                $display("FAIL wrap_write%0d got=%0d:%h exp=%0d:%h", i, wa[i], wd[i], AW'(i), smp[i]);
            end
        end
    endtask

    task automatic test_ext_abort;
        bit dn;
        logic [3:0] st;
        int k;
        smp.delete();
        repeat (30) smp.push_back(DW'($urandom));
        k = model_k(3, 0, 0, 1, NONE, 10);
        capture(3, 0, 0, 1, 8, NONE, 10, 15, dn, st);
        checks++;
        if (trig_addr_o !== AW'(k)) begin failures++; $display("FAIL ext_trig_addr got=%0d exp=%0d", trig_addr_o, AW'(k)); end
        checks++;
        if (st !== 4'b0000) begin failures++; $display("FAIL abort_flags busy/we/done/trig got=%b exp=0000", st); end
        checks++;
        if (wa.size() !== 15) begin failures++; $display("FAIL abort_writes got=%0d exp=15", wa.size()); end
        checks++;
        if ({busy_o, bram_we_o, done_o} !== 3'b000) begin
            failures++;
            $display("FAIL abort_stays_idle got=%b exp=000", {busy_o, bram_we_o, done_o});
        end
    endtask

    task automatic test_random;
        bit dn;
        logic [3:0] st;
        int src, lvl, hyst, pre, post, swf, k, n, x;
        for (int r = 0; r < 8; r++) begin
            src = int'($urandom_range(0, 2));
            lvl = int'($urandom_range(0, 400)) - 200;
            hyst = int'($urandom_range(0, 100));
            pre = int'($urandom_range(0, 10));
            post = int'($urandom_range(0, 10));
            swf = int'($urandom_range(pre + 1, 40));
            smp.delete();
            x = int'($urandom_range(0, 400)) - 200;
            repeat (60) begin
                x = x + int'($urandom_range(0, 80)) - 40;
                x = x > 400 ? 400 : x < -400 ? -400 : x;
                smp.push_back(DW'(x));
            end
            k = model_k(src, lvl, hyst, pre, swf, NONE);
            n = k + (post == 0 ? 1 : post);
            capture(src, lvl, hyst, pre, post, swf, NONE, NONE, dn, st);
            checks++;
            if (dn !== 1'b1 || wa.size() !== n) begin
                failures++;
                $display("FAIL rand%0d_writes got=%0d/%b exp=%0d/1", r, wa.size(), dn, n);
            end
            checks++;
            if (trig_addr_o !== AW'(k)) begin failures++; $display("FAIL rand%0d_trig_addr got=%0d exp=%0d", r, trig_addr_o, AW'(k)); end
            for (int i = 0; i < wa.size() && i < n; i++) begin
                checks++;
                if (wa[i] !== AW'(i) || wd[i] !== smp[i]) begin
                    failures++;
                    $display("FAIL rand%0d_write%0d got=%0d:%h exp=%0d:%h", r, i, wa[i], wd[i], AW'(i), smp[i]);
                end
            end
        end
    endtask

`ifdef TRIG_TIMESTAMP_EN
    task automatic test_timestamp;
        bit dn;
        logic [3:0] st;
        adc_rst_i = 1;
        repeat (2) @(negedge adc_clk_i);
        checks++;
        if (trig_ts_o !== 64'd0) begin failures++; $display("FAIL ts_reset got=%0d exp=0", trig_ts_o); end
        adc_rst_i = 0;
        repeat (997) @(negedge adc_clk_i);
        smp.delete();
        repeat (6) smp.push_back('0);
        capture(0, 0, 0, 0, 1, 0, NONE, NONE, dn, st);
        checks++;
        if (wc.size() < 2 || trig_ts_o !== 64'(wc[1])) begin
            failures++;
            $display("FAIL ts_latch got=%0d exp=%0d", trig_ts_o, wc.size() > 1 ? wc[1] : -1);
        end
    endtask
`endif

    initial begin
        @(negedge adc_clk_i);
        test_reset();
        test_rise();
        test_fall();
        test_min();
        test_back_to_back();
        test_ext_abort();
        test_random();
`ifdef TRIG_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
